// File: rtl/comms_pkg.sv
// Shared types and constants for the UART packet receive path.
// Parser state encoding and the default frame start marker.
package comms_pkg;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   typedef enum logic [1:0] {
      IDLE,
      LEN,
      PAYLOAD,
      CHECK
   } rx_pkt_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   output logic                     full,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == DEPTH_C);
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count
                  + (AW + 1)'(do_push)
                  - (AW + 1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/rx_packet_assembler.sv
// Frame parser for SYNC/LEN/payload/SUM packets from the UART receiver.
// Completed little-endian words stream out through a FIFO.
module rx_packet_assembler
   import comms_pkg::*;
#(
   parameter int         WORD_SIZE      = 32,
   parameter int         FIFO_DEPTH     = 16,
   parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
   parameter int         TIMEOUT_CYCLES = 50000
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic [7:0]           byte_in,
   input  logic                 byte_valid_in,
   output logic [WORD_SIZE-1:0] word_out,
   output logic                 word_valid_out,
   input  logic                 word_ready_in,
   output logic                 frame_done_out,
   output logic                 frame_error_out,
   output logic                 overflow_out,
   output logic                 busy_out
);

   localparam int WORD_BYTES = WORD_SIZE / 8;
   localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 0) ?
                       $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0] LAST_IDX  = BW'(WORD_BYTES - 1);
   localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

   rx_pkt_state_t state;
   rx_pkt_state_t state_n;

   logic [7:0]           len_q;
   logic [7:0]           word_cnt;
   logic [BW-1:0]        byte_idx;
   logic [7:0]           sum;
   logic [WORD_SIZE-1:0] shift;
   logic [WORD_SIZE-1:0] word_next;
   logic [TW-1:0]        tmo_cnt;

   logic tmo_hit;
   logic take;
   logic last_byte;
   logic push_en;
   logic done_d;
   logic err_d;

   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 fifo_pop;
   logic [WORD_SIZE-1:0] fifo_head;
   logic [CW-1:0]        fifo_count;

   // A timeout wins over a byte arriving in the same cycle.
   assign tmo_hit = (TIMEOUT_CYCLES != 0)
                  && (state != IDLE)
                  && (tmo_cnt == TMO_LIMIT);
   assign take      = byte_valid_in & ~tmo_hit;
   assign last_byte = (byte_idx == LAST_IDX);

   always_comb begin
      word_next = shift;
      word_next[8*byte_idx +: 8] = byte_in;
   end

   always_comb begin
      state_n = state;
      push_en = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      if (tmo_hit) begin
         state_n = IDLE;
         err_d   = 1'b1;
      end else if (byte_valid_in) begin
         unique case (state)
            IDLE: begin
               if (byte_in == SYNC_BYTE) begin
                  state_n = LEN;
               end
            end
            LEN: begin
               if (byte_in == 8'd0) begin
                  err_d   = 1'b1;
                  state_n = IDLE;
               end else begin
                  state_n = PAYLOAD;
               end
            end
            PAYLOAD: begin
               if (last_byte) begin
                  push_en = 1'b1;
                  if (word_cnt + 8'd1 == len_q) begin
                     state_n = CHECK;
                  end
               end
            end
            CHECK: begin
               if (byte_in == sum) begin
                  done_d = 1'b1;
               end else begin
                  err_d  = 1'b1;
               end
               state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         len_q           <= '0;
         word_cnt        <= '0;
         byte_idx        <= '0;
         sum             <= '0;
         shift           <= '0;
         tmo_cnt         <= '0;
         frame_done_out  <= 1'b0;
         frame_error_out <= 1'b0;
         overflow_out    <= 1'b0;
      end else begin
         frame_done_out  <= done_d;
         frame_error_out <= err_d;
         if (push_en && fifo_full && !fifo_pop) begin
            overflow_out <= 1'b1;
         end
         if (tmo_hit || take || state == IDLE) begin
            tmo_cnt <= '0;
         end else if (TIMEOUT_CYCLES != 0) begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end
         if (take) begin
            unique case (state)
               LEN: begin
                  len_q    <= byte_in;
                  word_cnt <= '0;
                  byte_idx <= '0;
                  sum      <= '0;
                  shift    <= '0;
               end
               PAYLOAD: begin
                  sum   <= sum + byte_in;
                  shift <= word_next;
                  if (last_byte) begin
                     byte_idx <= '0;
                     word_cnt <= word_cnt + 8'd1;
                  end else begin
                     byte_idx <= byte_idx + BW'(1);
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   sync_fifo #(
      .WIDTH (WORD_SIZE),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk_in),
      .rst       (rst_in),
      .push      (push_en),
      .push_data (word_next),
      .full      (fifo_full),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign word_valid_out = (fifo_count != '0);
   assign fifo_pop       = word_valid_out & word_ready_in;
   assign word_out       = fifo_empty ? '0 : fifo_head;
   assign busy_out       = (state != IDLE);

endmodule

// File: tb/tb_rx_packet_assembler.sv
// Self-checking bench for rx_packet_assembler (32-bit words, 4-deep FIFO,
// 100-cycle timeout) using a frame-level scoreboard plus literal checks.
module tb_rx_packet_assembler;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  byte_d = 8'h00;
   logic        byte_valid = 1'b0;
   logic [31:0] word;
   logic        word_valid;
   logic        ready = 1'b0;
   logic        frame_done;
   logic        frame_error;
   logic        overflow;
   logic        busy;

   always #5 clk = ~clk;

   rx_packet_assembler #(
      .WORD_SIZE      (32),
      .FIFO_DEPTH     (DEPTH),
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk_in          (clk),
      .rst_in          (rst),
      .byte_in         (byte_d),
      .byte_valid_in   (byte_valid),
      .word_out        (word),
      .word_valid_out  (word_valid),
      .word_ready_in   (ready),
      .frame_done_out  (frame_done),
      .frame_error_out (frame_error),
      .overflow_out    (overflow),
      .busy_out        (busy)
   );

   int compared   = 0;
   int mismatched = 0;
   int done_seen  = 0;
   int err_seen   = 0;

   logic [31:0] model_q[$];
   logic        drv_push = 1'b0;
   logic [31:0] drv_word = '0;
   logic        drv_done = 1'b0;
   logic        drv_err  = 1'b0;
   logic        exp_done = 1'b0;
   logic        exp_err  = 1'b0;
   logic        exp_ovf  = 1'b0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected FIFO contents and pulses, advanced once per cycle.
   always @(negedge clk) begin
      if (rst) begin
         model_q.delete();
         drv_push = 1'b0;
         drv_done = 1'b0;
         drv_err  = 1'b0;
         exp_done = 1'b0;
         exp_err  = 1'b0;
         exp_ovf  = 1'b0;
      end else begin
         check("valid", 32'(word_valid), 32'(model_q.size() != 0));
         if (model_q.size() != 0) begin
            check("word", word, model_q[0]);
         end
         check("done", 32'(frame_done), 32'(exp_done));
         check("error", 32'(frame_error), 32'(exp_err));
         check("overflow", 32'(overflow), 32'(exp_ovf));
         if (frame_done) done_seen++;
         if (frame_error) err_seen++;
         if (ready && model_q.size() != 0) begin
            void'(model_q.pop_front());
         end
         if (drv_push) begin
            if (model_q.size() < DEPTH) model_q.push_back(drv_word);
            else exp_ovf = 1'b1;
            drv_push = 1'b0;
         end
         exp_done = drv_done;
         exp_err  = drv_err;
         drv_done = 1'b0;
         drv_err  = 1'b0;
      end
   end

   task automatic slot(input logic v, input logic [7:0] b);
      @(posedge clk);
      #1;
      byte_valid = v;
      byte_d     = b;
   endtask

   task automatic idle(input int n);
      repeat (n) slot(1'b0, 8'h00);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst        = 1'b1;
      byte_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] len,
                             input logic [7:0] pay[$],
                             input logic force_sum,
                             input logic [7:0] forced,
                             input int ready_at);
      logic [7:0]  s;
      logic [7:0]  sb;
      logic [31:0] w;
      slot(1'b1, 8'hA5);
      slot(1'b1, len);
      s = 8'h00;
      w = '0;
      foreach (pay[i]) begin
         slot(1'b1, pay[i]);
         if (ready_at >= 0) ready = (i == ready_at);
         s = s + pay[i];
         w[8*(i%4) +: 8] = pay[i];
         if (i % 4 == 3) begin
            drv_push = 1'b1;
            drv_word = w;
         end
      end
      sb = force_sum ? forced : s;
      slot(1'b1, sb);
      if (ready_at >= 0) ready = 1'b0;
      if (sb == s) drv_done = 1'b1;
      else drv_err = 1'b1;
   endtask

   logic [7:0] f1[$];
   logic [7:0] f3[$];
   logic [7:0] f5[$];

   initial begin
      f1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      f3 = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 20; i++) f5.push_back(8'(8'h10 + i));

      idle(2);
      #1;
      rst = 1'b0;
      #1;
      check("rst_valid", 32'(word_valid), 0);
      check("rst_word", word, 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_pulses", 32'({frame_done, frame_error}), 0);

      // Good two-word frame, held then drained one word at a time.
      ready = 1'b0;
      send_frame(8'd2, f1, 1'b0, 8'h00, -1);
      idle(2);
      #2;
      check("t1_word0", word, 32'h44332211);
      check("t1_done", 32'(done_seen), 1);
      check("t1_err", 32'(err_seen), 0);
      slot(1'b0, 8'h00);
      ready = 1'b1;
      slot(1'b0, 8'h00);
      ready = 1'b0;
      #2;
      check("t1_word1", word, 32'h88776655);
      ready = 1'b1;
      idle(3);

      // Same frame with a bad checksum.
      send_frame(8'd2, f1, 1'b1, 8'h00, -1);
      idle(3);
      #2;
      check("t2_done", 32'(done_seen), 1);
      check("t2_err", 32'(err_seen), 1);

      // Junk before SYNC, LEN=0, then a good one-word frame.
      slot(1'b1, 8'h00);
      slot(1'b1, 8'hFF);
      slot(1'b1, 8'hA5);
      slot(1'b1, 8'h00);
      drv_err = 1'b1;
      send_frame(8'd1, f3, 1'b0, 8'h00, -1);
      idle(3);
      #2;
      check("t3_err", 32'(err_seen), 2);
      check("t3_done", 32'(done_seen), 2);

      // Inter-byte timeout mid-word.
      slot(1'b1, 8'hA5);
      slot(1'b1, 8'h01);
      slot(1'b1, 8'h11);
      slot(1'b1, 8'h22);
      idle(100);
      #2;
      check("t4_busy_before", 32'(busy), 1);
      slot(1'b0, 8'h00);
      drv_err = 1'b1;
      idle(2);
      #2;
      check("t4_busy", 32'(busy), 0);
      check("t4_err", 32'(err_seen), 3);
      check("t4_nowords", 32'(word_valid), 0);

      // Overflow: 5 words into a 4-deep FIFO with no consumer.
      ready = 1'b0;
      send_frame(8'd5, f5, 1'b0, 8'h00, -1);
      idle(2);
      #2;
      check("t5_head", word, 32'h13121110);
      check("t5_ovf", 32'(overflow), 1);
      check("t5_done", 32'(done_seen), 3);
      ready = 1'b1;
      idle(6);
      #2;
      check("t5_drained", 32'(word_valid), 0);
      check("t5_sticky", 32'(overflow), 1);

      // Full FIFO with a pop on the 5th push, then reset mid-payload.
      do_reset();
      ready = 1'b0;
      send_frame(8'd5, f5, 1'b0, 8'h00, 19);
      idle(2);
      #2;
      check("t6_ovf", 32'(overflow), 0);
      check("t6_head", word, 32'h17161514);
      slot(1'b1, 8'hA5);
      slot(1'b1, 8'h02);
      slot(1'b1, 8'h11);
      slot(1'b1, 8'h22);
      idle(1);
      #2;
      check("t6_busy_mid", 32'(busy), 1);
      do_reset();
      idle(3);
      #2;
      check("t6_busy", 32'(busy), 0);
      check("t6_valid", 32'(word_valid), 0);
      check("t6_err", 32'(err_seen), 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
